// File: rtl/reset_sequencer_if.sv
// Signal bundle between reset_sequencer and the rest of the chip: PLL lock,
// fatal error, per-domain reset requests and acknowledgements, and status.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 8
);
    logic                   pll_locked;
    logic                   fatal_error;
    logic [NUM_DOMAINS-1:0] domain_ready;
    logic [NUM_DOMAINS-1:0] domain_rstn;
    logic                   all_ready;
    logic [2:0]             state;
    logic                   timeout_err;
    logic [1:0]             retry_cnt;

    // Sequencer side.
    modport master (
        input  pll_locked,
        input  fatal_error,
        input  domain_ready,
        output domain_rstn,
        output all_ready,
        output state,
        output timeout_err,
        output retry_cnt
    );

    // Environment side: clock/PLL logic, error sources, domain synchronizers.
    modport slave (
        output pll_locked,
        output fatal_error,
        output domain_ready,
        input  domain_rstn,
        input  all_ready,
        input  state,
        input  timeout_err,
        input  retry_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases reset domains one at a time, in index order, once PLL lock has been
// stable. Any loss of lock, fatal error, domain drop-out or ack timeout pulls
// every domain back into reset; repeated timeouts end in a permanent lockout.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 8,
    parameter int LOCK_WAIT   = 64,
    parameter int STAGE_GAP   = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int MIN_HOLD    = 32,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    reset_sequencer_if.master seq_if
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] FIRST_BIT = NUM_DOMAINS'(1);

    // Terminal counts: the counter starts at 0 on state entry, so the event
    // fires on the edge where it holds (N-1), i.e. after exactly N cycles.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);

    localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY - 1);
    localparam logic [1:0] RETRY_SAT  = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_GAP      = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_e;

    // Input synchronizers.
    logic                   lock_meta_q;
    logic                   lock_s_q;
    logic [NUM_DOMAINS-1:0] ready_meta_q;
    logic [NUM_DOMAINS-1:0] ready_s_q;

    // FSM state and registered outputs.
    state_e                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [NUM_DOMAINS-1:0] rstn_q,   rstn_d;
    logic                   terr_q,   terr_d;
    logic [1:0]             retry_q,  retry_d;
    logic                   all_ready_q;

    // Decode helpers.
    logic [NUM_DOMAINS-1:0] k_bit;
    logic                   ack_k;
    logic [NUM_DOMAINS-1:0] acked;
    logic                   abort;

    assign k_bit = FIRST_BIT << idx_q;
    assign ack_k = |(ready_s_q & k_bit);

    // Two-flop synchronizers for the asynchronous lock and ready inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the 2-FF chain.
        if (!rstn) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            ready_meta_q <= '0;
            ready_s_q    <= '0;
        end else begin
            lock_meta_q  <= seq_if.pll_locked;
            lock_s_q     <= lock_meta_q;
            ready_meta_q <= seq_if.domain_ready;
            ready_s_q    <= ready_meta_q;
        end
    end

    // Abort detection: the domains already acknowledged are exactly the set
    // bits of the thermometer code, minus the one still awaiting its ack.
    always_comb begin
        acked = '0;
        if (state_q == ST_WAIT_ACK) begin
            acked = rstn_q & ~k_bit;
        end else if (state_q == ST_GAP || state_q == ST_RUN) begin
            acked = rstn_q;
        end
        abort = seq_if.fatal_error || !lock_s_q || (|(acked & ~ready_s_q));
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        // NOTE: every variable gets its default first, so no branch can leave
        // one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        terr_d  = terr_q;
        retry_d = retry_q;

        case (state_q)
            ST_HOLD: begin
                // Nothing is released yet; lock loss only restarts the count.
                rstn_d = '0;
                if (seq_if.fatal_error) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end else if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = FIRST_BIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_ACK: begin
                // Ack is tested before the timeout, so an ack arriving on the
                // timeout cycle wins.
                if (abort) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                end else if (ack_k) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == ACK_LAST) begin
                    terr_d  = 1'b1;
                    retry_d = (retry_q != RETRY_SAT) ? retry_q + 2'd1 : retry_q;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                    state_d = (retry_q == RETRY_LAST) ? ST_LOCKOUT : ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                // Extending the thermometer by one bit releases exactly one domain.
                if (abort) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    rstn_d  = (rstn_q << 1) | FIRST_BIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                end
            end

            ST_FAULT: begin
                // Hold everything in reset for MIN_HOLD cycles, then re-qualify lock.
                rstn_d = '0;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LOCKOUT: begin
                rstn_d = '0;
            end

            default: begin
                state_d = ST_FAULT;
                cnt_d   = '0;
                idx_d   = '0;
                rstn_d  = '0;
            end
        endcase
    end

    // FSM state register and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rstn_q      <= '0;
            terr_q      <= 1'b0;
            retry_q     <= '0;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rstn_q      <= rstn_d;
            terr_q      <= terr_d;
            retry_q     <= retry_d;
            all_ready_q <= (state_d == ST_RUN);
        end
    end

    assign seq_if.domain_rstn = rstn_q;
    assign seq_if.all_ready   = all_ready_q;
    assign seq_if.state       = state_q;
    assign seq_if.timeout_err = terr_q;
    assign seq_if.retry_cnt   = retry_q;

endmodule
